// File: rtl/add_sub_pkg.sv
// Shared encodings for the pipelined adder/subtracter: opcodes and the packed
// status-flag layout {negative, zero, overflow, carry}.
package add_sub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    localparam int FLAG_W     = 4;
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_NEG   = 3;

    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic neg,
        input logic zero,
        input logic ovf,
        input logic carry
    );
        pack_flags = {neg, zero, ovf, carry};
    endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit slice adder; also reports the carry entering the
// slice MSB so the top slice can derive signed overflow.
module add_sub_chunk
    import add_sub_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] beff,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in,
    output logic             zero
);

    logic [CHUNK:0] total_s;

    assign total_s  = {1'b0, a} + {1'b0, beff} + {{CHUNK{1'b0}}, cin};
    assign sum      = total_s[CHUNK-1:0];
    assign cout     = total_s[CHUNK];
    // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR.
    assign c_msb_in = total_s[CHUNK-1] ^ a[CHUNK-1] ^ beff[CHUNK-1];
    assign zero     = (total_s[CHUNK-1:0] == {CHUNK{1'b0}});

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement adder/subtracter: one CHUNK-bit slice per stage,
// carries registered between stages, valid/ready handshake with backpressure.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_negative
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("add_sub_pipe: WIDTH must be a positive multiple of CHUNK");
    end

    logic              advance_s;
    logic [WIDTH-1:0]  beff_s;
    logic              c0_s;

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] carry_r;
    logic [STAGES-1:0] zero_r;
    logic              ovf_r;
    logic [WIDTH-1:0]  a_r   [STAGES];
    logic [WIDTH-1:0]  b_r   [STAGES];
    logic [WIDTH-1:0]  res_r [STAGES];

    logic [STAGES-1:0] valid_nxt_s;
    logic [STAGES-1:0] carry_nxt_s;
    logic [STAGES-1:0] zero_nxt_s;
    logic              ovf_nxt_s;
    logic [WIDTH-1:0]  a_nxt_s   [STAGES];
    logic [WIDTH-1:0]  b_nxt_s   [STAGES];
    logic [WIDTH-1:0]  res_nxt_s [STAGES];

    logic [FLAG_W-1:0] flags_s;

    // A stalled output freezes the whole pipe, so readiness depends only on it.
    assign advance_s = ~valid_r[LAST] | out_ready;
    assign in_ready  = advance_s;

    // Subtraction is A + ~B + 1; the borrow ops feed in_cin as not-borrow.
    always_comb begin
        beff_s = in_b;
        c0_s   = 1'b0;
        case (in_op)
            OP_ADD: begin
                beff_s = in_b;
                c0_s   = 1'b0;
            end
            OP_SUB: begin
                beff_s = ~in_b;
                c0_s   = 1'b1;
            end
            OP_ADC: begin
                beff_s = in_b;
                c0_s   = in_cin;
            end
            OP_SBB: begin
                beff_s = ~in_b;
                c0_s   = in_cin;
            end
            default: begin
                beff_s = in_b;
                c0_s   = 1'b0;
            end
        endcase
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [WIDTH-1:0] src_a_s;
        logic [WIDTH-1:0] src_b_s;
        logic [WIDTH-1:0] src_res_s;
        logic [WIDTH-1:0] res_l_s;
        logic             src_c_s;
        logic             src_z_s;
        logic             src_v_s;
        logic [CHUNK-1:0] sum_s;
        logic             cout_s;
        logic             cmsb_s;
        logic             czero_s;

        if (g == 0) begin : g_head
            assign src_a_s   = in_a;
            assign src_b_s   = beff_s;
            assign src_c_s   = c0_s;
            assign src_res_s = {WIDTH{1'b0}};
            assign src_z_s   = 1'b1;
            assign src_v_s   = in_valid;
        end else begin : g_body
            assign src_a_s   = a_r[g-1];
            assign src_b_s   = b_r[g-1];
            assign src_c_s   = carry_r[g-1];
            assign src_res_s = res_r[g-1];
            assign src_z_s   = zero_r[g-1];
            assign src_v_s   = valid_r[g-1];
        end

        add_sub_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a        (src_a_s[g*CHUNK +: CHUNK]),
            .beff     (src_b_s[g*CHUNK +: CHUNK]),
            .cin      (src_c_s),
            .sum      (sum_s),
            .cout     (cout_s),
            .c_msb_in (cmsb_s),
            .zero     (czero_s)
        );

        // Splice this stage's slice into the partial result from earlier stages.
        always_comb begin
            res_l_s                   = src_res_s;
            res_l_s[g*CHUNK +: CHUNK] = sum_s;
        end

        assign valid_nxt_s[g] = src_v_s;
        assign carry_nxt_s[g] = cout_s;
        assign zero_nxt_s[g]  = src_z_s & czero_s;
        assign a_nxt_s[g]     = src_a_s;
        assign b_nxt_s[g]     = src_b_s;
        assign res_nxt_s[g]   = res_l_s;

        if (g == LAST) begin : g_tail
            assign ovf_nxt_s = cmsb_s ^ cout_s;
        end
    end

    // Stage registers: cleared on reset, shift as one when advancing, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {STAGES{1'b0}};
            carry_r <= {STAGES{1'b0}};
            zero_r  <= {STAGES{1'b0}};
            ovf_r   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= {WIDTH{1'b0}};
                b_r[k]   <= {WIDTH{1'b0}};
                res_r[k] <= {WIDTH{1'b0}};
            end
        end else if (advance_s) begin
            valid_r <= valid_nxt_s;
            carry_r <= carry_nxt_s;
            zero_r  <= zero_nxt_s;
            ovf_r   <= ovf_nxt_s;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= a_nxt_s[k];
                b_r[k]   <= b_nxt_s[k];
                res_r[k] <= res_nxt_s[k];
            end
        end
    end

    assign flags_s = pack_flags(res_r[LAST][WIDTH-1], zero_r[LAST], ovf_r, carry_r[LAST]);

    assign out_valid    = valid_r[LAST];
    assign out_result   = res_r[LAST];
    assign out_carry    = flags_s[FLAG_CARRY];
    assign out_overflow = flags_s[FLAG_OVF];
    assign out_zero     = flags_s[FLAG_ZERO];
    assign out_negative = flags_s[FLAG_NEG];

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: three configurations (64/16, 64/64, 32/8) driven in
// parallel, checked against an arithmetic reference model and literal vectors.
module tb_add_sub_pipe;
    import add_sub_pkg::*;

    typedef struct packed {
        logic [67:0] val;
        int          acc;
        logic        seen;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_a, in_b;
    logic [1:0]  in_op;
    logic        in_cin;
    logic        out_ready;
    logic [2:0]  irdy, ovld, ocar, oovf, ozer, oneg;
    logic [63:0] r0, r1;
    logic [31:0] r2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat [3] = '{4, 1, 4};
    int wid [3] = '{64, 64, 32};
    int stall_cyc [3] = '{-1, -1, -1};
    int popcnt [3] = '{0, 0, 0};
    logic [2:0]  hold_prev = 3'b000;
    logic [68:0] snap [3];
    sb_t q0[$], q1[$], q2[$];

    // literal expectations: {carry, overflow, zero, negative, result}
    localparam logic [67:0] LIT_ADD   = {4'b0000, 64'h0000_0000_0001_0000};
    localparam logic [67:0] LIT_SUB57 = {4'b0001, 64'hFFFF_FFFF_FFFF_FFFE};
    localparam logic [67:0] LIT_SUB75 = {4'b1000, 64'h0000_0000_0000_0002};
    localparam logic [67:0] LIT_OVF   = {4'b0101, 64'h8000_0000_0000_0000};
    localparam logic [67:0] LIT_ADC   = {4'b1010, 64'h0000_0000_0000_0000};
    localparam logic [67:0] LIT_SBB   = {4'b0001, 64'hFFFF_FFFF_FFFF_FFFD};
    localparam logic [67:0] LIT_S32   = {4'b0001, 64'h0000_0000_FFFF_FFFE};

    logic [63:0] t1_a  [5] = '{64'h0000_0000_0000_FFFF, 64'd5, 64'd7,
                               64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] t1_b  [5] = '{64'd1, 64'd7, 64'd5, 64'd1, 64'd0};
    logic [1:0]  t1_op [5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    logic        t1_c  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    add_sub_pipe #(.WIDTH(64), .CHUNK(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
        .out_valid(ovld[0]), .out_ready(out_ready), .out_result(r0),
        .out_carry(ocar[0]), .out_overflow(oovf[0]), .out_zero(ozer[0]), .out_negative(oneg[0]));

    add_sub_pipe #(.WIDTH(64), .CHUNK(64)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
        .out_valid(ovld[1]), .out_ready(out_ready), .out_result(r1),
        .out_carry(ocar[1]), .out_overflow(oovf[1]), .out_zero(ozer[1]), .out_negative(oneg[1]));

    add_sub_pipe #(.WIDTH(32), .CHUNK(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_op(in_op), .in_cin(in_cin),
        .out_valid(ovld[2]), .out_ready(out_ready), .out_result(r2),
        .out_carry(ocar[2]), .out_overflow(oovf[2]), .out_zero(ozer[2]), .out_negative(oneg[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain modular arithmetic; borrow and overflow from sign rules.
    function automatic logic [67:0] model(input logic [63:0] a_i, input logic [63:0] b_i,
                                          input logic [1:0] op, input logic cin, input int w);
        logic [64:0] mask, a, b, full, bor;
        logic [63:0] r;
        logic        c, v, sa, sb, sr, is_add;
        mask   = (65'd1 << w) - 65'd1;
        a      = {1'b0, a_i} & mask;
        b      = {1'b0, b_i} & mask;
        is_add = (op == 2'b00) || (op == 2'b10);
        if (is_add) begin
            full = a + b + {64'd0, (op == 2'b10) ? cin : 1'b0};
            c    = full[w];
        end else begin
            bor  = {64'd0, (op == 2'b11) ? ~cin : 1'b0};
            full = a - b - bor;
            c    = (a >= b + bor);
        end
        r  = full[63:0] & mask[63:0];
        sa = a[w-1];
        sb = b[w-1];
        sr = r[w-1];
        v  = is_add ? ((sa == sb) && (sr != sa)) : ((sa != sb) && (sr != sa));
        return {c, v, (r == 64'd0), sr, r};
    endfunction

    function automatic logic [67:0] got(input int d);
        case (d)
            0:       return {ocar[0], oovf[0], ozer[0], oneg[0], r0};
            1:       return {ocar[1], oovf[1], ozer[1], oneg[1], r1};
            default: return {ocar[2], oovf[2], ozer[2], oneg[2], 32'd0, r2};
        endcase
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic sb_t q_front(input int d);
        case (d)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void q_set_front(input int d, input sb_t e);
        case (d)
            0:       q0[0] = e;
            1:       q1[0] = e;
            default: q2[0] = e;
        endcase
    endfunction

    function automatic void q_pop(input int d);
        case (d)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void q_push(input int d, input sb_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    task automatic chk(input string nm, input int d, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d act=%h exp=%h", nm, d, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard compare on every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            q2.delete();
            hold_prev = 3'b000;
        end else begin
            for (int d = 0; d < 3; d++) begin
                logic [67:0] g;
                sb_t         e;
                g = got(d);
                if (hold_prev[d])
                    chk("hold", d, {3'd0, ovld[d], g}, {3'd0, snap[d]});
                if (ovld[d]) begin
                    if (q_size(d) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious dut%0d act=%h exp=none", d, g);
                    end else begin
                        e = q_front(d);
                        chk("result", d, {4'd0, g}, {4'd0, e.val});
                        if (!e.seen) begin
                            if (stall_cyc[d] < e.acc)
                                chk("latency", d, 72'(cyc - e.acc), 72'(lat[d]));
                            else
                                chk("latency_min", d, 72'(cyc - e.acc >= lat[d]), 72'd1);
                            e.seen = 1'b1;
                            q_set_front(d, e);
                        end
                        if (out_ready) begin
                            q_pop(d);
                            popcnt[d]++;
                        end else begin
                            stall_cyc[d] = cyc;
                        end
                    end
                end
                hold_prev[d] = ovld[d] & ~out_ready;
                snap[d]      = {ovld[d], g};
                if (in_valid && irdy[d])
                    q_push(d, '{val: model(in_a, in_b, in_op, in_cin, wid[d]), acc: cyc, seen: 1'b0});
            end
        end
    end

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return {$urandom, $urandom};
            default: return {$urandom, 32'h7FFF_FFFF + 32'($urandom_range(0, 1))};
        endcase
    endfunction

    initial begin
        int i;
        rst_n = 1'b0; in_valid = 1'b0; in_a = 64'd0; in_b = 64'd0;
        in_op = 2'b00; in_cin = 1'b0; out_ready = 1'b1;

        chk("m_add",   0, {4'd0, model(64'h0000_0000_0000_FFFF, 64'd1, 2'b00, 1'b0, 64)}, {4'd0, LIT_ADD});
        chk("m_sub57", 0, {4'd0, model(64'd5, 64'd7, 2'b01, 1'b0, 64)}, {4'd0, LIT_SUB57});
        chk("m_sub75", 0, {4'd0, model(64'd7, 64'd5, 2'b01, 1'b0, 64)}, {4'd0, LIT_SUB75});
        chk("m_ovf",   0, {4'd0, model(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 64)}, {4'd0, LIT_OVF});
        chk("m_adc",   0, {4'd0, model(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'b10, 1'b1, 64)}, {4'd0, LIT_ADC});
        chk("m_sbb",   0, {4'd0, model(64'd5, 64'd7, 2'b11, 1'b0, 64)}, {4'd0, LIT_SBB});
        chk("m_s32",   2, {4'd0, model(64'd5, 64'd7, 2'b01, 1'b0, 32)}, {4'd0, LIT_S32});

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_out", d, {3'd0, ovld[d], got(d)}, 72'd0);
            chk("rst_rdy", d, {71'd0, irdy[d]}, 72'd1);
        end
        step();
        rst_n = 1'b1;
        step();

        // Directed arithmetic vectors, back to back, no stall.
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 5);
            if (c < 5) begin
                in_a = t1_a[c]; in_b = t1_b[c]; in_op = t1_op[c]; in_cin = t1_c[c];
            end
            @(negedge clk);
            chk("t1_valid", 0, {71'd0, ovld[0]}, {71'd0, (c >= 4 && c < 9)});
            chk("t1_valid", 1, {71'd0, ovld[1]}, {71'd0, (c >= 1 && c < 6)});
            chk("t1_valid", 2, {71'd0, ovld[2]}, {71'd0, (c >= 4 && c < 9)});
            if (c == 4) chk("t1_add", 0, {4'd0, got(0)}, {4'd0, LIT_ADD});
            if (c == 4) chk("t1_add", 2, {4'd0, got(2)}, {4'd0, LIT_ADD});
            if (c == 1) chk("t1_add", 1, {4'd0, got(1)}, {4'd0, LIT_ADD});
            if (c == 5) chk("t1_sub57", 0, {4'd0, got(0)}, {4'd0, LIT_SUB57});
            if (c == 7) chk("t1_ovf", 0, {4'd0, got(0)}, {4'd0, LIT_OVF});
            if (c == 8) chk("t1_adc", 0, {4'd0, got(0)}, {4'd0, LIT_ADC});
            if (c == 8) chk("t1_adc", 2, {4'd0, got(2)}, {4'd0, LIT_ADC});
            if (c == 5) chk("t1_adc", 1, {4'd0, got(1)}, {4'd0, LIT_ADC});
            step();
        end

        // Stream of 8 ADDs with downstream stalled in cycles 5-7.
        popcnt = '{0, 0, 0};
        i = 0;
        for (int c = 0; c < 17; c++) begin
            in_valid  = (i < 8);
            in_a      = 64'(i);
            in_b      = 64'(i);
            in_op     = 2'b00;
            in_cin    = 1'b0;
            out_ready = !(c >= 5 && c <= 7);
            @(negedge clk);
            for (int d = 0; d < 3; d++)
                chk("stall_rdy", d, {71'd0, irdy[d]}, {71'd0, !(c >= 5 && c <= 7)});
            if (in_valid && irdy[0]) i++;
            step();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int d = 0; d < 3; d++)
            chk("stall_count", d, 72'(popcnt[d]), 72'd8);

        // Reset with two operations in flight.
        for (int c = 0; c < 11; c++) begin
            in_valid = (c == 0 || c == 1 || c == 5);
            in_a     = 64'd100 + 64'(c);
            in_b     = 64'd3;
            in_op    = 2'b00;
            rst_n    = !(c >= 2 && c < 4);
            @(negedge clk);
            chk("rstmid_valid", 0, {71'd0, ovld[0]}, {71'd0, (c == 9)});
            chk("rstmid_valid", 2, {71'd0, ovld[2]}, {71'd0, (c == 9)});
            if (c >= 2 && c <= 5)
                for (int d = 0; d < 3; d++)
                    chk("rstmid_rdy", d, {71'd0, irdy[d]}, 72'd1);
            step();
        end

        // Random mix of all opcodes with random backpressure.
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            in_op     = 2'($urandom_range(0, 3));
            in_cin    = 1'($urandom_range(0, 1));
            in_a      = pick();
            in_b      = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk("drain", d, 72'(q_size(d)), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
